// File: rtl/stack_sequencer.sv
// stack_sequencer: accepts one stack command at a time over valid/ready,
// expands it into one or two stackOP steps for register_stack, computes
// the write value from the live top-of-stack operands, and tracks depth
// with sticky overflow/underflow flags.
module stack_sequencer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] cmd_imm,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       stackOP,
    output logic [WIDTH-1:0] w,
    output logic             stack_reset,
    output logic [6:0]       depth,
    output logic             overflow,
    output logic             underflow,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {S_RST, S_IDLE, S_STEP1, S_STEP2} state_t;

    localparam logic [6:0] DEPTH_MAX = 7'(DEPTH);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_REPL = 3'd2;
    localparam logic [2:0] OP_POP  = 3'd3;
    localparam logic [2:0] OP_POP2 = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;

    localparam logic [3:0] C_NOP   = 4'd0;
    localparam logic [3:0] C_PUSH  = 4'd1;
    localparam logic [3:0] C_POP   = 4'd2;
    localparam logic [3:0] C_DROP2 = 4'd3;
    localparam logic [3:0] C_SWAP  = 4'd4;
    localparam logic [3:0] C_DUP   = 4'd5;
    localparam logic [3:0] C_OVER  = 4'd6;
    localparam logic [3:0] C_ADD   = 4'd7;
    localparam logic [3:0] C_SUB   = 4'd8;
    localparam logic [3:0] C_AND   = 4'd9;
    localparam logic [3:0] C_OR    = 4'd10;
    localparam logic [3:0] C_XOR   = 4'd11;
    localparam logic [3:0] C_NIP   = 4'd12;
    localparam logic [3:0] C_DUP2  = 4'd13;
    localparam logic [3:0] C_CLEAR = 4'd14;
    localparam logic [3:0] C_ILL   = 4'd15;

    state_t           state_q, state_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [6:0]       depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [1:0]       req_depth;
    logic             rejected;
    logic [WIDTH-1:0] alu_res;
    logic [6:0]       depth_inc1;
    logic [6:0]       depth_inc2;

    // Operand requirement of the latched command, ALU result and saturating increments.
    always_comb begin
        req_depth = 2'd2;
        unique case (cmd_q)
            C_NOP, C_PUSH, C_CLEAR, C_ILL: req_depth = 2'd0;
            C_POP, C_DUP:                  req_depth = 2'd1;
            default:                       req_depth = 2'd2;
        endcase
        rejected = (cmd_q == C_ILL) || (depth_q < {5'd0, req_depth});

        alu_res = '0;
        unique case (cmd_q)
            C_ADD:   alu_res = b + a;
            C_SUB:   alu_res = b - a;
            C_AND:   alu_res = b & a;
            C_OR:    alu_res = b | a;
            C_XOR:   alu_res = b ^ a;
            default: alu_res = '0;
        endcase

        depth_inc1 = (depth_q >= DEPTH_MAX) ? DEPTH_MAX : depth_q + 7'd1;
        depth_inc2 = (depth_q + 7'd2 > DEPTH_MAX) ? DEPTH_MAX : depth_q + 7'd2;
    end

    // Next-state and step outputs; stack signals are combinational from state and a/b.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        imm_d       = imm_q;
        depth_d     = depth_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cmd_ready   = 1'b0;
        stackOP     = OP_NOP;
        w           = '0;
        stack_reset = 1'b0;

        unique case (state_q)
            S_RST: begin
                stack_reset = 1'b1;
                state_d     = S_IDLE;
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_d   = cmd;
                    imm_d   = cmd_imm;
                    state_d = S_STEP1;
                end
            end
            S_STEP1: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (rejected) begin
                    err_d = 1'b1;
                    unf_d = 1'b1;
                end else begin
                    unique case (cmd_q)
                        C_PUSH, C_DUP, C_OVER: begin
                            stackOP = OP_PUSH;
                            w       = (cmd_q == C_PUSH) ? imm_q :
                                      (cmd_q == C_DUP)  ? a : b;
                            depth_d = depth_inc1;
                            if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
                        end
                        C_POP: begin
                            stackOP = OP_POP;
                            depth_d = depth_q - 7'd1;
                        end
                        C_DROP2: begin
                            stackOP = OP_POP2;
                            depth_d = depth_q - 7'd2;
                        end
                        C_SWAP: stackOP = OP_SWAP;
                        C_ADD, C_SUB, C_AND, C_OR, C_XOR: begin
                            stackOP = OP_REPL;
                            w       = alu_res;
                            depth_d = depth_q - 7'd1;
                        end
                        C_NIP: begin
                            stackOP = OP_SWAP;
                            done_d  = 1'b0;
                            state_d = S_STEP2;
                        end
                        C_DUP2: begin
                            stackOP = OP_PUSH;
                            w       = b;
                            if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
                            done_d  = 1'b0;
                            state_d = S_STEP2;
                        end
                        C_CLEAR: begin
                            stack_reset = 1'b1;
                            depth_d     = '0;
                            ovf_d       = 1'b0;
                            unf_d       = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_STEP2: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (cmd_q == C_NIP) begin
                    stackOP = OP_POP;
                    depth_d = depth_q - 7'd1;
                end else begin
                    // Second DUP2 push sees the stack already one deeper than depth_q.
                    stackOP = OP_PUSH;
                    w       = b;
                    depth_d = depth_inc2;
                    if (depth_q >= DEPTH_MAX - 7'd1) ovf_d = 1'b1;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    // State register; reset aborts any command in flight.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            cmd_q   <= '0;
            imm_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            imm_q   <= imm_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Testbench for stack_sequencer: a behavioural register_stack drives a/b,
// and a queue-based command model predicts stack contents, depth and flags.
module tb_stack_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic [3:0]  cmd;
    logic [15:0] cmd_imm;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] a, b;
    logic [2:0]  stackOP;
    logic [15:0] w;
    logic        stack_reset;
    logic [6:0]  depth;
    logic        overflow, underflow, done, err;

    int vectors = 0;
    int miscompares = 0;

    stack_sequencer #(.DEPTH(64), .WIDTH(16)) dut (
        .CLK(CLK), .reset(reset), .cmd(cmd), .cmd_imm(cmd_imm),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .a(a), .b(b),
        .stackOP(stackOP), .w(w), .stack_reset(stack_reset), .depth(depth),
        .overflow(overflow), .underflow(underflow), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    // Attached register_stack: 64-entry shift stack, zeros shift in from the bottom.
    logic [15:0] env_mem  [64];
    logic [15:0] env_next [64];
    assign a = env_mem[0];
    assign b = env_mem[1];

    always_comb begin
        for (int i = 0; i < 64; i++) env_next[i] = env_mem[i];
        if (stack_reset) begin
            for (int i = 0; i < 64; i++) env_next[i] = '0;
        end else begin
            case (stackOP)
                3'd1: begin
                    env_next[0] = w;
                    for (int i = 1; i < 64; i++) env_next[i] = env_mem[i-1];
                end
                3'd2: begin
                    env_next[0] = w;
                    for (int i = 1; i < 63; i++) env_next[i] = env_mem[i+1];
                    env_next[63] = '0;
                end
                3'd3: begin
                    for (int i = 0; i < 63; i++) env_next[i] = env_mem[i+1];
                    env_next[63] = '0;
                end
                3'd4: begin
                    for (int i = 0; i < 62; i++) env_next[i] = env_mem[i+2];
                    env_next[62] = '0;
                    env_next[63] = '0;
                end
                3'd5: begin
                    env_next[0] = env_mem[1];
                    env_next[1] = env_mem[0];
                end
                default: ;
            endcase
        end
    end

    always @(posedge CLK) begin
        for (int i = 0; i < 64; i++) env_mem[i] <= env_next[i];
    end

    // Reference model: front of queue is top of stack.
    logic [15:0] ref_q[$];
    bit ref_ovf = 0;
    bit ref_unf = 0;

    task automatic ref_push(input logic [15:0] v);
        if (ref_q.size() == 64) begin
            ref_ovf = 1;
            void'(ref_q.pop_back());
        end
        ref_q.push_front(v);
    endtask

    task automatic ref_apply(input logic [3:0] c, input logic [15:0] imm, output bit rej);
        int d;
        int need;
        logic [15:0] ra, rb, res;
        d  = ref_q.size();
        ra = (d > 0) ? ref_q[0] : 16'h0;
        rb = (d > 1) ? ref_q[1] : 16'h0;
        need = (c == 0 || c == 1 || c == 14) ? 0 : (c == 2 || c == 5) ? 1 : 2;
        rej = (c == 15) || (d < need);
        if (rej) begin
            ref_unf = 1;
            return;
        end
        res = 16'h0;
        case (c)
            4'd1: ref_push(imm);
            4'd2: void'(ref_q.pop_front());
            4'd3: begin void'(ref_q.pop_front()); void'(ref_q.pop_front()); end
            4'd4: begin ref_q[0] = rb; ref_q[1] = ra; end
            4'd5: ref_push(ra);
            4'd6: ref_push(rb);
            4'd7, 4'd8, 4'd9, 4'd10, 4'd11: begin
                case (c)
                    4'd7:    res = rb + ra;
                    4'd8:    res = rb - ra;
                    4'd9:    res = rb & ra;
                    4'd10:   res = rb | ra;
                    default: res = rb ^ ra;
                endcase
                void'(ref_q.pop_front());
                ref_q[0] = res;
            end
            4'd12: ref_q.delete(1);
            4'd13: begin ref_push(rb); ref_push(ra); end
            4'd14: begin ref_q.delete(); ref_ovf = 0; ref_unf = 0; end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stack();
        int bad_idx;
        bad_idx = -1;
        for (int i = 0; i < ref_q.size(); i++)
            if (bad_idx < 0 && env_mem[i] !== ref_q[i]) bad_idx = i;
        check("stack_first_bad_index", 32'(bad_idx), 32'hFFFF_FFFF);
        check("top_a", {16'h0, a}, {16'h0, (ref_q.size() > 0) ? ref_q[0] : 16'h0});
    endtask

    // One command: wait for ready, present it, hold junk on the bus while busy, check completion.
    task automatic do_cmd(input logic [3:0] c, input logic [15:0] imm);
        int wait_cnt;
        int steps;
        bit rej;
        wait_cnt = 0;
        while (cmd_ready !== 1'b1 && wait_cnt < 10) begin
            @(negedge CLK);
            wait_cnt++;
        end
        check("ready_before_cmd", {31'h0, cmd_ready}, 32'h1);
        cmd       = c;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        ref_apply(c, imm, rej);
        steps = (!rej && (c == 4'd12 || c == 4'd13)) ? 2 : 1;
        @(negedge CLK);
        check("done_in_step1", {31'h0, done}, 32'h0);
        check("ready_in_step1", {31'h0, cmd_ready}, 32'h0);
        if (rej) begin
            check("rejected_stackop", {29'h0, stackOP}, 32'h0);
            check("rejected_stack_reset", {31'h0, stack_reset}, 32'h0);
        end
        cmd     = 4'($urandom_range(0, 15));
        cmd_imm = 16'($urandom);
        if (steps == 2) begin
            @(negedge CLK);
            check("done_in_step2", {31'h0, done}, 32'h0);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
        check("done_pulse", {31'h0, done}, 32'h1);
        check("err", {31'h0, err}, {31'h0, rej});
        check("depth", {25'h0, depth}, 32'(ref_q.size()));
        check("overflow", {31'h0, overflow}, {31'h0, ref_ovf});
        check("underflow", {31'h0, underflow}, {31'h0, ref_unf});
        check_stack();
        $display("cmd=%0d imm=%04h rej=%0d depth=%0d a=%04h b=%04h ovf=%0d unf=%0d",
                 c, imm, rej, depth, a, b, overflow, underflow);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset     = 1'b0;
        cmd       = 4'd0;
        cmd_imm   = 16'h0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_stackop", {29'h0, stackOP}, 32'h0);
        check("rst_w", {16'h0, w}, 32'h0);
        check("rst_stack_reset", {31'h0, stack_reset}, 32'h1);
        check("rst_depth", {25'h0, depth}, 32'h0);
        check("rst_flags", {28'h0, overflow, underflow, done, err}, 32'h0);
        reset = 1'b1;
        @(negedge CLK);
        check("post_rst_ready", {31'h0, cmd_ready}, 32'h1);
        check("post_rst_stack_reset", {31'h0, stack_reset}, 32'h0);

        // Arithmetic
        do_cmd(4'd1, 16'd1);
        do_cmd(4'd1, 16'd4);
        do_cmd(4'd7, 16'd0);
        check("plan_add_a", {16'h0, a}, 32'd5);
        do_cmd(4'd1, 16'd7);
        do_cmd(4'd1, 16'd3);
        do_cmd(4'd8, 16'd0);
        check("plan_sub_a", {16'h0, a}, 32'd4);
        do_cmd(4'd1, 16'd0);
        do_cmd(4'd1, 16'd4);
        do_cmd(4'd8, 16'd0);
        check("plan_sub_wrap", {16'h0, a}, 32'hFFFC);
        do_cmd(4'd9, 16'd0);
        do_cmd(4'd1, 16'h0F0F);
        do_cmd(4'd11, 16'd0);

        // NIP and DUP2
        do_cmd(4'd14, 16'd0);
        do_cmd(4'd1, 16'd1);
        do_cmd(4'd1, 16'd2);
        do_cmd(4'd12, 16'd0);
        check("plan_nip_depth", {25'h0, depth}, 32'd1);
        do_cmd(4'd1, 16'd5);
        do_cmd(4'd13, 16'd0);
        check("plan_dup2_b", {16'h0, b}, 32'd2);
        check("plan_dup2_depth", {25'h0, depth}, 32'd4);

        // Underflow and illegal code
        do_cmd(4'd14, 16'd0);
        do_cmd(4'd2, 16'd0);
        check("plan_underflow", {31'h0, underflow}, 32'h1);
        do_cmd(4'd14, 16'd0);
        check("plan_clear_unf", {31'h0, underflow}, 32'h0);
        do_cmd(4'd15, 16'd0);
        do_cmd(4'd6, 16'd0);
        do_cmd(4'd14, 16'd0);

        // Overflow: 65 pushes, 64 pops, one more pop rejected
        for (int i = 1; i <= 65; i++) do_cmd(4'd1, 16'(i));
        check("plan_full_depth", {25'h0, depth}, 32'd64);
        check("plan_overflow", {31'h0, overflow}, 32'h1);
        for (int i = 0; i < 64; i++) do_cmd(4'd2, 16'd0);
        check("plan_empty_a", {16'h0, a}, 32'd0);
        do_cmd(4'd2, 16'd0);
        check("plan_pop_empty_err", {31'h0, err}, 32'h1);

        // DUP2 near full: second push overflows
        do_cmd(4'd14, 16'd0);
        for (int i = 0; i < 63; i++) do_cmd(4'd1, 16'(i + 100));
        do_cmd(4'd13, 16'd0);

        // Reset during STEP2 of DUP2
        do_cmd(4'd14, 16'd0);
        do_cmd(4'd1, 16'd9);
        do_cmd(4'd1, 16'd8);
        cmd       = 4'd13;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        @(negedge CLK);
        check("step2_push_op", {29'h0, stackOP}, 32'd1);
        reset = 1'b0;
        #1;
        check("midcmd_rst_stackop", {29'h0, stackOP}, 32'h0);
        check("midcmd_rst_stack_reset", {31'h0, stack_reset}, 32'h1);
        check("midcmd_rst_depth", {25'h0, depth}, 32'h0);
        check("midcmd_rst_done", {31'h0, done}, 32'h0);
        ref_q.delete();
        ref_ovf = 0;
        ref_unf = 0;
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check("midcmd_release_ready", {31'h0, cmd_ready}, 32'h1);
        check("midcmd_stack_cleared", {16'h0, a}, 32'h0);
        $display("reset during DUP2 step 2 depth=%0d ready=%0d", depth, cmd_ready);

        // Randomized commands against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      do_cmd(4'd1, 16'($urandom));
            else if (r < 42) do_cmd(4'd14, 16'd0);
            else             do_cmd(4'($urandom_range(0, 15)), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
